// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: upstream, data-memory, writeback and error signals of the memory stage
interface lsu_mem_stage_if;
  logic        valid_in;
  logic        ready_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
  modport master (
    output valid_in, opcode, funct3, rd, alu_result, store_data, mem_ack, mem_rdata,
    input  ready_out, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           wb_valid, wb_rd, wb_data, err_valid, err_cause, err_addr
  );
  modport slave (
    input  valid_in, opcode, funct3, rd, alu_result, store_data, mem_ack, mem_rdata,
    output ready_out, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           wb_valid, wb_rd, wb_data, err_valid, err_cause, err_addr
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store memory stage with single-outstanding req/ack port and registered writeback
module lsu_mem_stage #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  lsu_mem_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic        load_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic        is_load, is_store, legal, misal;
  logic [3:0]  strb;
  logic [31:0] wdata, lane, ld_data;
  assign bus.ready_out = state == IDLE;
  always_comb begin
    is_load  = bus.opcode == 7'b0000011;
    is_store = bus.opcode == 7'b0100011;
    legal    = is_load ? !(bus.funct3 inside {3'b011, 3'b110, 3'b111})
                       : !bus.funct3[2] && bus.funct3[1:0] != 2'b11;
    misal    = bus.funct3[1:0] == 2'b01 ? bus.alu_result[0] :
               bus.funct3[1:0] == 2'b10 ? |bus.alu_result[1:0] : 1'b0;
    strb     = bus.funct3[1:0] == 2'b00 ? 4'b0001 << bus.alu_result[1:0] :
               bus.funct3[1:0] == 2'b01 ? (bus.alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata    = bus.funct3[1:0] == 2'b00 ? {4{bus.store_data[7:0]}} :
               bus.funct3[1:0] == 2'b01 ? {2{bus.store_data[15:0]}} : bus.store_data;
    // aligned accesses only reach here, so a byte-granular shift also selects the halfword
    lane     = rdata_q >> {addr_q[1:0], 3'b000};
    ld_data  = f3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
               f3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
               f3_q == 3'b100 ? {24'h0, lane[7:0]} :
               f3_q == 3'b101 ? {16'h0, lane[15:0]} : rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      load_q        <= 1'b0;
      f3_q          <= '0;
      rd_q          <= '0;
      addr_q        <= '0;
      rdata_q       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.err_valid <= 1'b0;
      bus.err_cause <= '0;
      bus.err_addr  <= '0;
    end else begin
      bus.wb_valid  <= 1'b0;
      bus.err_valid <= 1'b0;
      case (state)
        IDLE: if (bus.valid_in) begin
          load_q <= is_load;
          f3_q   <= bus.funct3;
          rd_q   <= bus.rd;
          addr_q <= bus.alu_result;
          if (!(is_load || is_store)) begin
            bus.wb_valid <= 1'b1;
            bus.wb_rd    <= bus.rd;
            bus.wb_data  <= bus.alu_result;
          end else if (!legal || misal) begin
            bus.err_valid <= 1'b1;
            bus.err_cause <= legal ? 2'd1 : 2'd2;
            bus.err_addr  <= bus.alu_result;
          end else begin
            state         <= REQ;
            cnt           <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= is_store;
            bus.mem_addr  <= {bus.alu_result[31:2], 2'b00};
            bus.mem_wstrb <= is_store ? strb : 4'b0000;
            bus.mem_wdata <= is_store ? wdata : 32'h0;
          end
        end
        REQ: if (bus.mem_ack) begin
          state         <= RESP;
          rdata_q       <= bus.mem_rdata;
          bus.mem_req   <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.mem_wstrb <= '0;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state         <= IDLE;
          bus.mem_req   <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.mem_wstrb <= '0;
          bus.err_valid <= 1'b1;
          bus.err_cause <= 2'd3;
          bus.err_addr  <= addr_q;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: begin
          state        <= IDLE;
          bus.wb_valid <= 1'b1;
          bus.wb_rd    <= load_q ? rd_q : 5'd0;
          bus.wb_data  <= load_q ? ld_data : 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed checks of pass-through, loads, stores, errors, timeout and reset
module tb_lsu_mem_stage;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  lsu_mem_stage_if bus();
  lsu_mem_stage #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_IMM = 7'b0010011;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] sd);
    bus.valid_in = 1; bus.opcode = op; bus.funct3 = f3; bus.rd = r;
    bus.alu_result = a; bus.store_data = sd;
  endtask
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] sd);
    drive(op, f3, r, a, sd);
    @(negedge clk);
    bus.valid_in = 0;
  endtask
  task automatic test_reset;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %b want 0", bus.err_valid); end
    checks++; if (bus.mem_wstrb !== 4'b0) begin errors++; $display("FAIL reset_wstrb got %b want 0", bus.mem_wstrb); end
    checks++; if (bus.err_cause !== 2'd0) begin errors++; $display("FAIL reset_err_cause got %0d want 0", bus.err_cause); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_out); end
  endtask
  task automatic test_passthrough;
    issue(OP_IMM, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL pass_wb_valid got %b want 1", bus.wb_valid); end
    checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL pass_wb_rd got %0d want 5", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'h1234) begin errors++; $display("FAIL pass_wb_data got %h want 00001234", bus.wb_data); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL pass_mem_req got %b want 0", bus.mem_req); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL pass_wb_pulse got %b want 0", bus.wb_valid); end
  endtask
  task automatic test_back_to_back;
    drive(OP_IMM, 3'b000, 5'd7, 32'hAAAA_0001, 32'h0);
    @(negedge clk);
    drive(7'b0110011, 3'b000, 5'd9, 32'h5555_0002, 32'h0);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'hAAAA_0001) begin
      errors++; $display("FAIL b2b_first got v=%b rd=%0d d=%h want 1/7/aaaa0001", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    @(negedge clk);
    bus.valid_in = 0;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd9 || bus.wb_data !== 32'h5555_0002) begin
      errors++; $display("FAIL b2b_second got v=%b rd=%0d d=%h want 1/9/55550002", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    @(negedge clk);
  endtask
  task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    bus.mem_rdata = 32'h80FF_0000;
    issue(OP_LOAD, f3, 5'd3, a, 32'h0);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== {a[31:2], 2'b00} || bus.mem_wstrb !== 4'b0) begin
      errors++; $display("FAIL load_req f3=%0d got req=%b we=%b addr=%h strb=%b", f3, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb); end
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL load_busy got %b want 0", bus.ready_out); end
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    checks++; if (bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL load_resp got req=%b wb=%b want 0/0", bus.mem_req, bus.wb_valid); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3 || bus.wb_data !== exp) begin
      errors++; $display("FAIL load_wb f3=%0d got v=%b rd=%0d d=%h want 1/3/%h", f3, bus.wb_valid, bus.wb_rd, bus.wb_data, exp); end
    @(negedge clk);
  endtask
  task automatic test_store_sh;
    issue(OP_STORE, 3'b001, 5'd12, 32'h0000_0202, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200 ||
                    bus.mem_wdata !== 32'hBEEF_BEEF || bus.mem_wstrb !== 4'b1100) begin
        errors++; $display("FAIL sh_hold cyc%0d got req=%b we=%b addr=%h wd=%h strb=%b", i,
                           bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); end
      if (i == 3) bus.mem_ack = 1;
      @(negedge clk);
    end
    bus.mem_ack = 0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sh_req_drop got %b want 0", bus.mem_req); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
      errors++; $display("FAIL sh_wb got v=%b rd=%0d d=%h want 1/0/0", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    @(negedge clk);
  endtask
  task automatic test_store_sb;
    issue(OP_STORE, 3'b000, 5'd1, 32'h0000_0301, 32'h1234_5678);
    checks++; if (bus.mem_wstrb !== 4'b0010 || bus.mem_wdata !== 32'h7878_7878 || bus.mem_addr !== 32'h300) begin
      errors++; $display("FAIL sb_lane got strb=%b wd=%h addr=%h want 0010/78787878/300", bus.mem_wstrb, bus.mem_wdata, bus.mem_addr); end
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0) begin
      errors++; $display("FAIL sb_wb got v=%b rd=%0d want 1/0", bus.wb_valid, bus.wb_rd); end
    @(negedge clk);
  endtask
  task automatic test_error(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [1:0] cause);
    issue(op, f3, 5'd4, a, 32'h0);
    checks++; if (bus.err_valid !== 1'b1 || bus.err_cause !== cause || bus.err_addr !== a) begin
      errors++; $display("FAIL err f3=%0d a=%h got v=%b c=%0d ea=%h want 1/%0d", f3, a, bus.err_valid, bus.err_cause, bus.err_addr, cause); end
    checks++; if (bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL err_side got req=%b wb=%b want 0/0", bus.mem_req, bus.wb_valid); end
    @(negedge clk);
    checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", bus.err_valid); end
  endtask
  task automatic test_timeout;
    int n = 0;
    issue(OP_LOAD, 3'b010, 5'd6, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (!bus.mem_req) break;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_req_cycles got %0d want 8", n); end
    checks++; if (bus.err_valid !== 1'b1 || bus.err_cause !== 2'd3 || bus.err_addr !== 32'h40) begin
      errors++; $display("FAIL timeout_err got v=%b c=%0d ea=%h want 1/3/40", bus.err_valid, bus.err_cause, bus.err_addr); end
    checks++; if (bus.ready_out !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got rdy=%b wb=%b want 1/0", bus.ready_out, bus.wb_valid); end
    @(negedge clk);
  endtask
  task automatic test_ack_idle;
    bus.mem_ack = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0 || bus.err_valid !== 1'b0 || bus.ready_out !== 1'b1) begin
      errors++; $display("FAIL ack_idle got wb=%b err=%b rdy=%b want 0/0/1", bus.wb_valid, bus.err_valid, bus.ready_out); end
    bus.mem_ack = 0;
  endtask
  task automatic test_reset_mid;
    issue(OP_LOAD, 3'b010, 5'd8, 32'h0000_0080, 32'h0);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b want 1", bus.mem_req); end
    #2 rst = 1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b want 0", bus.mem_req); end
    bus.mem_ack = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.wb_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
        errors++; $display("FAIL rstmid_after cyc%0d got wb=%b req=%b want 0/0", i, bus.wb_valid, bus.mem_req); end
    end
    bus.mem_ack = 0;
  endtask
  initial begin
    rst = 1;
    bus.valid_in = 0; bus.opcode = '0; bus.funct3 = '0; bus.rd = '0;
    bus.alu_result = '0; bus.store_data = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 0;
    @(negedge clk);
    test_passthrough();
    test_back_to_back();
    test_load(3'b000, 32'h0000_0103, 32'hFFFF_FF80);
    test_load(3'b100, 32'h0000_0103, 32'h0000_0080);
    test_load(3'b001, 32'h0000_0102, 32'hFFFF_80FF);
    test_load(3'b101, 32'h0000_0102, 32'h0000_80FF);
    test_load(3'b010, 32'h0000_0100, 32'h80FF_0000);
    test_store_sh();
    test_store_sb();
    test_error(OP_LOAD, 3'b010, 32'h0000_0006, 2'd1);
    test_error(OP_STORE, 3'b001, 32'h0000_0201, 2'd1);
    test_error(OP_LOAD, 3'b011, 32'h0000_0100, 2'd2);
    test_error(OP_STORE, 3'b100, 32'h0000_0100, 2'd2);
    test_timeout();
    test_ack_idle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage directly downstream of the ALU in the RISC-V core. It consumes the ALU result as the effective address for LOAD/STORE, and passes it through unchanged as writeback data for every other opcode. It drives a single-outstanding req/ack data-memory port and generates byte strobes and load extraction with sign/zero extension. It raises misalignment, illegal-width and timeout errors, and presents a registered writeback bundle.

Parameters:
TIMEOUT, 64, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  upstream instruction valid
ready_out  out  1  stage can accept (state==IDLE)
opcode  in  7  instruction opcode
funct3  in  3  width/sign select
rd  in  5  destination register
alu_result  in  32  effective address or result
store_data  in  32  rs2 value for stores
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables (0 on reads)
mem_ack  in  1  request completed; mem_rdata valid same cycle
mem_rdata  in  32  read word
wb_valid  out  1  writeback pulse
wb_rd  out  5  writeback register (0 for stores)
wb_data  out  32  writeback value
err_valid  out  1  error pulse
err_cause  out  2  1=misaligned, 2=illegal funct3, 3=timeout
err_addr  out  32  faulting effective address

Behaviour:
- Reset (async, immediate): state IDLE; mem_req, mem_we, wb_valid, err_valid = 0; mem_wstrb, err_cause = 0; all data/address outputs = 0. Reset mid-transaction drops mem_req in the same instant; a later mem_ack is ignored.
- FSM states: IDLE, REQ, RESP.
- Accept: valid_in && ready_out. Opcode, funct3, rd, addr and store data are latched on accept.
- Non-memory opcode: stay in IDLE. Next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd. Latency 1; back-to-back accepts allowed.
- Legal widths: load funct3 000/001/010/100/101; store funct3 000/001/010. Any other funct3 -> err cause 2, pulsed next cycle, no memory access, no wb.
- Misaligned access -> err cause 1, next cycle, no memory access. Halfword with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned.
- Legal LOAD/STORE: go to REQ.
  - In REQ, mem_req=1 and address/data/strobe stay stable until ack.
  - ack in REQ -> RESP; load data is registered on the ack cycle.
  - RESP lasts one cycle: wb_valid=1, then return to IDLE.
  - Minimum latency is 3 cycles from accept to wb_valid (ack on first REQ cycle).
- Store strobes and write data:
  - sb: wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - sh: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata={2{data[15:0]}}.
  - sw: wstrb=4'b1111.
- Store writeback: wb_valid pulses with wb_rd=0 and wb_data=0 (retire marker).
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw takes the full word.
- Timeout: a cycle counter runs in REQ. If it reaches TIMEOUT with no ack: drop mem_req, pulse err cause 3 with err_addr, return to IDLE, no wb.
- mem_ack outside REQ is ignored.
- err_valid and wb_valid are never high together. Each is a single-cycle pulse.

Test Plan:
- addi-style pass-through: opcode 0010011, alu_result=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, mem_req stays 0.
- lb at 0x103 with mem_rdata=0x80FF_0000, ack on first REQ cycle -> mem_addr=0x100, wstrb=0, wb_data=0xFFFF_FF80 three cycles after accept; lbu on same data -> 0x0000_0080.
- sh at 0x202, store_data=0xDEAD_BEEF, ack after 4 cycles -> mem_req/address/data/strobe held stable 4 cycles with wstrb=1100, wdata=0xBEEF_BEEF; wb_rd=0.
- lw at 0x0000_0006 -> no mem_req, err_valid=1, err_cause=1, err_addr=0x6; same for sh at 0x201.
- load funct3=011 -> err_cause=2; load with no ack and TIMEOUT=8 -> mem_req high exactly 8 cycles, then err_cause=3 and ready_out=1.
- Assert rst while in REQ -> mem_req falls without a clock edge; a subsequent ack produces no wb_valid.
